// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin merge of two writeback FIFOs into the single register-file write port
// Ports: clk, rst (async, active-high)
//        a_valid/a_ready/a_rd/a_data, b_valid/b_ready/b_rd/b_data : per-requester write handshakes
//        wer/rd/regdata : registered register-file write port
//        pending : bit r set while a write to x<r> is queued or in the write stage
//        idle    : both FIFOs empty and no write in flight
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            wer,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] regdata,
  output logic [31:0]     pending,
  output logic            idle
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]       a_rq [DEPTH];
  logic [XLEN-1:0]  a_dq [DEPTH];
  logic [4:0]       b_rq [DEPTH];
  logic [XLEN-1:0]  b_dq [DEPTH];
  logic [AW:0]      a_wp, a_rp, b_wp, b_rp, a_cnt, b_cnt;
  logic             a_ne, b_ne, a_push, b_push, ga, gb, ptr;
  logic [DEPTH-1:0] a_vld, b_vld;
  assign a_cnt = a_wp - a_rp;
  assign b_cnt = b_wp - b_rp;
  assign a_ne = a_cnt != '0;
  assign b_ne = b_cnt != '0;
  assign a_ready = !rst && a_cnt != (AW+1)'(DEPTH);
  assign b_ready = !rst && b_cnt != (AW+1)'(DEPTH);
  // x0 writes complete the handshake but are dropped here
  assign a_push = a_valid && a_ready && a_rd != 5'd0;
  assign b_push = b_valid && b_ready && b_rd != 5'd0;
  // ptr=0 favours A, ptr=1 favours B
  assign ga = a_ne && (!b_ne || !ptr);
  assign gb = b_ne && !ga;
  assign idle = !a_ne && !b_ne && !wer;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_wp <= '0;
      a_rp <= '0;
      b_wp <= '0;
      b_rp <= '0;
      ptr <= 1'b0;
      wer <= 1'b0;
      rd <= '0;
      regdata <= '0;
    end else begin
      a_wp <= a_wp + (AW+1)'(a_push);
      b_wp <= b_wp + (AW+1)'(b_push);
      a_rp <= a_rp + (AW+1)'(ga);
      b_rp <= b_rp + (AW+1)'(gb);
      wer <= ga || gb;
      if (ga || gb) begin
        ptr <= ga;
        rd <= ga ? a_rq[a_rp[AW-1:0]] : b_rq[b_rp[AW-1:0]];
        regdata <= ga ? a_dq[a_rp[AW-1:0]] : b_dq[b_rp[AW-1:0]];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (a_push) begin
      a_rq[a_wp[AW-1:0]] <= a_rd;
      a_dq[a_wp[AW-1:0]] <= a_data;
    end
    if (b_push) begin
      b_rq[b_wp[AW-1:0]] <= b_rd;
      b_dq[b_wp[AW-1:0]] <= b_data;
    end
  end
  // a physical slot is occupied when its distance from the read pointer is below the count
  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    assign a_vld[i] = {1'b0, AW'(i) - a_rp[AW-1:0]} < a_cnt;
    assign b_vld[i] = {1'b0, AW'(i) - b_rp[AW-1:0]} < b_cnt;
  end
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_vld[i]) pending[a_rq[i]] = 1'b1;
      if (b_vld[i]) pending[b_rq[i]] = 1'b1;
    end
    if (wer) pending[rd] = 1'b1;
    pending[0] = 1'b0;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random checks of regfile_wb_arbiter against a queue-based model
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;
  typedef struct packed {logic [4:0] r; logic [31:0] d;} ent_t;
  logic clk, rst;
  logic a_valid, b_valid, a_ready, b_ready, wer, idle;
  logic [4:0] a_rd, b_rd, rd;
  logic [31:0] a_data, b_data, regdata, pending;
  int checks, errors, acc;
  ent_t qa[$], qb[$];
  bit m_ptr_b, m_wer;
  logic [4:0] m_rd;
  logic [31:0] m_data;
  logic [31:0] m_regs [32];
  logic [31:0] d_regs [32];
  int log_q[$];
  bit seen_a_block;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .wer(wer), .rd(rd), .regdata(regdata), .pending(pending), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    qa.delete();
    qb.delete();
    m_ptr_b = 1'b0;
    m_wer = 1'b0;
    m_rd = '0;
    m_data = '0;
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] p;
    p = '0;
    foreach (qa[i]) p[qa[i].r] = 1'b1;
    foreach (qb[i]) p[qb[i].r] = 1'b1;
    if (m_wer) p[m_rd] = 1'b1;
    return p;
  endfunction

  task automatic check_outputs();
    chk("a_ready", 32'(a_ready), 32'(!rst && qa.size() < DEPTH));
    chk("b_ready", 32'(b_ready), 32'(!rst && qb.size() < DEPTH));
    chk("wer", 32'(wer), 32'(m_wer));
    chk("rd", 32'(rd), 32'(m_rd));
    chk("regdata", regdata, m_data);
    chk("pending", pending, m_pend());
    chk("idle", 32'(idle), 32'(qa.size() == 0 && qb.size() == 0 && !m_wer));
  endtask

  task automatic set_a(input logic v, input logic [4:0] r, input logic [31:0] d);
    a_valid = v;
    a_rd = r;
    a_data = d;
  endtask

  task automatic set_b(input logic v, input logic [4:0] r, input logic [31:0] d);
    b_valid = v;
    b_rd = r;
    b_data = d;
  endtask

  // one clock: check outputs, record the observed commit, advance the model, cross the edge
  task automatic tick();
    bit ra, rb, ga, gb;
    ent_t h;
    h = '0;
    check_outputs();
    if (wer) d_regs[rd] = regdata;
    log_q.push_back(wer ? int'(rd) : 0);
    if (a_valid && a_ready && a_rd != 0) acc++;
    if (b_valid && b_ready && b_rd != 0) acc++;
    if (a_valid && !a_ready) seen_a_block = 1'b1;
    if (rst) model_reset();
    else begin
      ra = qa.size() < DEPTH;
      rb = qb.size() < DEPTH;
      if (m_wer) m_regs[m_rd] = m_data;
      ga = qa.size() != 0 && (qb.size() == 0 || !m_ptr_b);
      gb = qb.size() != 0 && !ga;
      if (ga) begin
        h = qa.pop_front();
        m_ptr_b = 1'b1;
      end else if (gb) begin
        h = qb.pop_front();
        m_ptr_b = 1'b0;
      end
      m_wer = ga || gb;
      if (m_wer) begin
        m_rd = h.r;
        m_data = h.d;
      end
      if (a_valid && ra && a_rd != 0) qa.push_back({a_rd, a_data});
      if (b_valid && rb && b_rd != 0) qb.push_back({b_rd, b_data});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    set_a(0, 0, 0);
    set_b(0, 0, 0);
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    tick();
    rst = 1'b0;
    #1;
    check_outputs();
  endtask

  initial begin
    int exp_log[7];
    int n_commit;
    checks = 0;
    errors = 0;
    acc = 0;
    seen_a_block = 1'b0;
    foreach (m_regs[i]) begin
      m_regs[i] = '0;
      d_regs[i] = '0;
    end
    model_reset();
    rst = 1'b1;
    set_a(0, 0, 0);
    set_b(0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    chk("reset_idle", 32'(idle), 32'd1);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'({a_ready, b_ready}), 32'd3);

    // single write with latency check
    set_a(1, 5'd5, 32'hDEADBEEF);
    tick();
    set_a(0, 0, 0);
    chk("single_pend_N", 32'(pending[5]), 32'd1);
    chk("single_wer_N", 32'(wer), 32'd0);
    tick();
    chk("single_wer_N1", 32'(wer), 32'd1);
    chk("single_rd_N1", 32'(rd), 32'd5);
    chk("single_data_N1", regdata, 32'hDEADBEEF);
    chk("single_pend_N1", 32'(pending[5]), 32'd1);
    tick();
    chk("single_pend_N2", 32'(pending[5]), 32'd0);
    chk("single_commit", d_regs[5], 32'hDEADBEEF);

    // contention: A x1,x2 / B x3,x4 on the same edges
    reset_pulse();
    log_q.delete();
    set_a(1, 5'd1, 32'hA1);
    set_b(1, 5'd3, 32'hB3);
    tick();
    set_a(1, 5'd2, 32'hA2);
    set_b(1, 5'd4, 32'hB4);
    tick();
    set_a(0, 0, 0);
    set_b(0, 0, 0);
    repeat (5) tick();
    exp_log = '{0, 0, 1, 3, 2, 4, 0};
    foreach (exp_log[i]) chk($sformatf("contention_order[%0d]", i), 32'(log_q[i]), 32'(exp_log[i]));

    // rd=0 writes are accepted and dropped
    reset_pulse();
    set_a(1, 5'd0, 32'h1234);
    chk("rd0_ready", 32'(a_ready), 32'd1);
    tick();
    set_a(0, 0, 0);
    chk("rd0_idle", 32'(idle), 32'd1);
    chk("rd0_pending", pending, 32'd0);
    tick();
    chk("rd0_wer", 32'(wer), 32'd0);
    chk("rd0_idle2", 32'(idle), 32'd1);

    // same-rd race: later commit (B) wins
    reset_pulse();
    set_a(1, 5'd7, 32'h11);
    set_b(1, 5'd7, 32'h22);
    tick();
    set_a(0, 0, 0);
    set_b(0, 0, 0);
    tick();
    chk("race_first", regdata, 32'h11);
    chk("race_pend1", 32'(pending[7]), 32'd1);
    tick();
    chk("race_second", regdata, 32'h22);
    chk("race_pend2", 32'(pending[7]), 32'd1);
    tick();
    chk("race_pend_clear", 32'(pending[7]), 32'd0);
    chk("race_final", d_regs[7], 32'h22);

    // backpressure: both sides saturated, no loss and no duplicates
    reset_pulse();
    log_q.delete();
    acc = 0;
    seen_a_block = 1'b0;
    for (int n = 0; n < 10; n++) begin
      set_a(1, 5'(8 + n), 32'h100 + n);
      set_b(1, 5'(20 + n % 10), 32'h200 + n);
      tick();
    end
    set_a(0, 0, 0);
    set_b(0, 0, 0);
    repeat (6) tick();
    n_commit = 0;
    foreach (log_q[i]) if (log_q[i] != 0) n_commit++;
    chk("bp_no_loss", 32'(n_commit), 32'(acc));
    chk("bp_a_blocked", 32'(seen_a_block), 32'd1);

    // asynchronous reset mid-stream discards everything
    for (int n = 0; n < 4; n++) begin
      set_a(1, 5'(1 + n), 32'h300 + n);
      set_b(1, 5'(11 + n), 32'h400 + n);
      tick();
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_wer", 32'(wer), 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_readies", 32'({a_ready, b_ready}), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    @(negedge clk);
    tick();
    set_a(0, 0, 0);
    set_b(0, 0, 0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'({a_ready, b_ready}), 32'd3);
    log_q.delete();
    repeat (3) tick();
    foreach (log_q[i]) chk("rst_no_wer", 32'(log_q[i]), 32'd0);

    // random traffic with occasional x0 and heavy rd collisions
    for (int n = 0; n < 400; n++) begin
      set_a(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      set_b(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      tick();
    end
    set_a(0, 0, 0);
    set_b(0, 0, 0);
    repeat (6) tick();
    for (int r = 1; r < 32; r++) chk($sformatf("final_x%0d", r), d_regs[r], m_regs[r]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
